pulse_train_generator: RTL and testbench

- Transmit-side counterpart of the posedge detector. Drives a registered single-bit waveform made of N rectangular pulses.
- High width and low width are programmable per burst. Each pulse gives the downstream detector exactly one rising edge.
- Used as an on-chip stimulus source and as a strobe generator feeding edge-detector inputs.

---
 rtl/pulse_train_generator_pkg.sv | 11 +
 rtl/pulse_train_generator_phase_timer.sv | 25 ++
 rtl/pulse_train_generator.sv | 117 +++++++++++
 tb/tb_pulse_train_generator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_generator_pkg.sv
// Shared state encoding and defaults for the pulse train generator.
package pulse_train_generator_pkg;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;
endpackage

// File: rtl/pulse_train_generator_phase_timer.sv
// Loadable phase down-counter; o_expire marks the last cycle of a phase.
module pulse_train_generator_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expire
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // A zero length is clamped to one clock so every phase is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_load)           r_cnt <= (i_load_val == '0) ? ONE : i_load_val;
    else if (r_cnt != '0)      r_cnt <= r_cnt - ONE;
  end

  assign o_expire = (r_cnt == ONE);
endmodule

// File: rtl/pulse_train_generator.sv
// Burst generator: N registered pulses with programmable high/low widths.
module pulse_train_generator
  import pulse_train_generator_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  output logic             data_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_sent
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_num, r_high, r_low, r_ps, w_ps_nxt, w_load_val;
  logic             r_data, r_busy, r_done;
  logic             w_load, w_clr, w_latch, w_expire;

  pulse_train_generator_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_clr      (w_clr),
    .i_load_val (w_load_val),
    .o_expire   (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ps_nxt    = r_ps;
    w_load      = 1'b0;
    w_load_val  = r_high;
    w_clr       = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_latch = 1'b1;
          if (num_pulses != '0) begin
            // First rising edge is counted on the HIGH entry edge.
            w_state_nxt = ST_HIGH;
            w_load      = 1'b1;
            w_load_val  = high_cycles;
            w_ps_nxt    = ONE;
          end else begin
            w_state_nxt = ST_FINISH;
            w_ps_nxt    = '0;
          end
        end
      end
      ST_HIGH: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end else if (w_expire) begin
          w_state_nxt = ST_LOW;
          w_load      = 1'b1;
          w_load_val  = r_low;
        end
      end
      ST_LOW: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end else if (w_expire) begin
          if (r_ps < r_num) begin
            w_state_nxt = ST_HIGH;
            w_load      = 1'b1;
            w_load_val  = r_high;
            w_ps_nxt    = r_ps + ONE;
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in dedicated flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_num   <= '0;
      r_high  <= '0;
      r_low   <= '0;
      r_ps    <= '0;
      r_data  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ps    <= w_ps_nxt;
      r_data  <= (w_state_nxt == ST_HIGH);
      r_busy  <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_LOW);
      r_done  <= (w_state_nxt == ST_FINISH);
      if (w_latch) begin
        r_num  <= num_pulses;
        r_high <= high_cycles;
        r_low  <= low_cycles;
      end
    end
  end

  assign data_out    = r_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pulses_sent = r_ps;
endmodule

// File: tb/tb_pulse_train_generator.sv
// Scoreboard bench: stimulus queues expected per-cycle outputs, monitor compares.
module tb_pulse_train_generator;
  logic       clk, rst_n, start, abort;
  logic [7:0] num_pulses, high_cycles, low_cycles, pulses_sent;
  logic       data_out, busy, done;

  typedef struct packed {
    logic       d;
    logic       b;
    logic       dn;
    logic [7:0] ps;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   rises = 0;
  int   last_ps = 0;
  logic prev_d = 1'b0;

  pulse_train_generator #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .num_pulses  (num_pulses),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic exp_t mk(input logic d, input logic b, input logic dn, input int ps);
    exp_t e;
    e.d = d; e.b = b; e.dn = dn; e.ps = 8'(ps);
    return e;
  endfunction

  // Expected waveform of one burst; ab>0 means abort is sampled at the end of cycle ab.
  task automatic push_burst(input int n, input int h, input int l, input int ab);
    int hh, ll, cyc, ps;
    bit stop;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    cyc = 0; ps = 0; stop = 0;
    if (n == 0) exp_q.push_back(mk(0, 0, 1, 0));
    else begin
      for (int p = 1; p <= n; p++) begin
        for (int i = 0; i < hh + ll; i++) begin
          if (!stop) begin
            cyc++;
            ps = p;
            exp_q.push_back(mk(i < hh, 1, 0, p));
            if (ab != 0 && cyc == ab) stop = 1;
          end
        end
      end
      if (!stop) exp_q.push_back(mk(0, 0, 1, ps));
    end
    exp_q.push_back(mk(0, 0, 0, ps));
    exp_q.push_back(mk(0, 0, 0, ps));
    last_ps = ps;
  endtask

  task automatic drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic go(input int n, input int h, input int l);
    num_pulses = 8'(n); high_cycles = 8'(h); low_cycles = 8'(l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input string name, input int n, input int h, input int l);
    @(negedge clk);
    rises = 0;
    push_burst(n, h, l, 0);
    go(n, h, l);
    drain();
    check(name, rises, n);
  endtask

  // Monitor: one expected entry per cycle, sampled just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (data_out && !prev_d) rises++;
      prev_d = data_out;
      if (exp_q.size() != 0) begin
        exp_t e, a;
        e = exp_q.pop_front();
        a = mk(data_out, busy, done, int'(pulses_sent));
        if (a != e)
          $display("FAIL cycle_out: got d=%0b busy=%0b done=%0b ps=%0d expected d=%0b busy=%0b done=%0b ps=%0d (t=%0t)",
                   a.d, a.b, a.dn, a.ps, e.d, e.b, e.dn, e.ps, $time);
        else n_pass++;
        n_total++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    num_pulses = '0; high_cycles = '0; low_cycles = '0;
    #3;
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ps", pulses_sent, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("rises_3x2x3", 3, 2, 3);
    run("rises_n0", 0, 5, 5);
    run("rises_2x0x0", 2, 0, 0);

    // Abort during the second high phase (cycle 10 of a 4/4/4 burst).
    @(negedge clk);
    rises = 0;
    push_burst(4, 4, 4, 10);
    go(4, 4, 4);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain();
    check("rises_abort", rises, 2);
    run("rises_after_abort", 1, 2, 2);

    // Abort and start together in IDLE: nothing happens.
    @(negedge clk);
    exp_q.push_back(mk(0, 0, 0, last_ps));
    exp_q.push_back(mk(0, 0, 0, last_ps));
    num_pulses = 8'd3; high_cycles = 8'd1; low_cycles = 8'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    drain();

    // Mid-burst field changes and re-start; start+abort during FINISH.
    @(negedge clk);
    rises = 0;
    push_burst(3, 2, 3, 0);
    go(3, 2, 3);
    repeat (3) @(negedge clk);
    num_pulses = 8'd7; high_cycles = 8'd9; low_cycles = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    drain();
    check("rises_midchange", rises, 3);

    // Asynchronous reset in the middle of a high phase.
    @(negedge clk);
    exp_q.push_back(mk(1, 1, 0, 1));
    exp_q.push_back(mk(1, 1, 0, 1));
    go(3, 5, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_data", data_out, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ps", pulses_sent, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_ps = 0;
    @(negedge clk);
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    drain();

    run("rises_255", 255, 1, 1);
    check("final_ps", pulses_sent, 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
